men_lsu: RTL
============

# men_lsu

Memory-access stage of the pipeline: the consumer end of the EX/MEM register. It takes the registered EX results (`men_*`), performs loads and stores on a req/ack data bus, and stalls the upstream pipeline while a bus access is outstanding. It registers the final write-back triple (`wb_*`) for the MEM/WB side.

## Interface

Parameters:
- `ACK_TIMEOUT`, default 255: cycles in BUSY without `d_ack` before the access is aborted; 0 disables the watchdog.
- `TO_W`, default 8: watchdog counter width; `ACK_TIMEOUT` < 2^`TO_W`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `men_w_reg_data`  in  32  ALU result from EX/MEM.
- `men_w_reg_addr`  in  5  destination register.
- `men_wd`  in  1  register-write enable.
- `men_mem_op`  in  4  memory operation:
  - 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW.
  - 9–15 are treated as none.
- `men_mem_addr`  in  32  effective byte address.
- `men_store_data`  in  32  store source (low bits used for SB/SH).
- `d_req`  out  1  bus request, registered.
- `d_we`  out  1  1 = write.
- `d_addr`  out  32  word address (`men_mem_addr` with [1:0] forced to 0).
- `d_sel`  out  4  byte enables, little-endian (bit *i* = byte lane *i*).
- `d_wdata`  out  32  write data, lane-replicated.
- `d_rdata`  in  32  read data, valid when `d_ack`=1.
- `d_ack`  in  1  one-cycle completion strobe.
- `stall_req`  out  1  combinational; hold EX/MEM and earlier stages.
- `wb_w_reg_data`  out  32  registered write-back data.
- `wb_w_reg_addr`  out  5  registered write-back register.
- `wb_wd`  out  1  registered write-back enable.
- `exc_misalign`  out  1  one-cycle registered pulse on a misaligned access.
- `bus_err`  out  1  one-cycle registered pulse on a watchdog abort.

## Operation

States: IDLE, BUSY.

IDLE, op = none:
- Next edge: `wb_*` <= `men_*`.
- `stall_req`=0.

IDLE, misaligned memory op:
- Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
- No bus access; `stall_req`=0.
- Next edge: `wb_wd`<=0, `exc_misalign`<=1.

IDLE, aligned memory op:
- `stall_req`=1.
- Next edge: go to BUSY, `d_req`<=1, latch `d_we`/`d_addr`/`d_sel`/`d_wdata`, clear the watchdog counter.
- Write a bubble: `wb_wd`<=0.

BUSY:
- `d_*` outputs are held stable until ack or abort.
- `stall_req` = ~`d_ack`.
- On `d_ack`=1:
  - Next edge: `d_req`<=0, go to IDLE.
  - `wb_w_reg_addr`<=`men_w_reg_addr`, `wb_wd`<=`men_wd`.
  - `wb_w_reg_data` <= extracted load data for loads, `men_w_reg_data` for stores.
  - Because `stall_req` drops in the ack cycle, EX/MEM advances on the same edge.
- Watchdog, when `ACK_TIMEOUT`≠0:
  - The counter increments each BUSY cycle without ack.
  - When it reaches `ACK_TIMEOUT`: abort, `d_req`<=0, `bus_err`<=1, `wb_wd`<=0, go to IDLE.
  - `stall_req`=0 in that cycle.
- `d_ack` seen in IDLE is ignored.

Byte lanes (a = addr[1:0]):
- SB: `d_sel` = 1<<a; `d_wdata` = {4{store[7:0]}}.
- SH: `d_sel` = 0011 (a=0) or 1100 (a=2); `d_wdata` = {2{store[15:0]}}.
- SW: `d_sel` = 1111.
- Loads use the same `d_sel` pattern as the corresponding store size.
- LB/LBU select byte `d_rdata`[8a+7:8a] and sign- or zero-extend it to 32 bits.
- LH/LHU select `d_rdata`[31:16] when a=2, else [15:0], and sign- or zero-extend.

Reset (asynchronous, may occur mid-access):
- State <= IDLE; all registered outputs <= 0.
- `d_req` drops immediately, without waiting for a clock edge; a pending ack is discarded.

## Timing

- Non-memory op: 1-cycle latency from EX/MEM into `wb_*`, full throughput.
- Memory op: minimum 2 cycles (IDLE cycle plus ack in the first BUSY cycle).
  - Each extra wait cycle before ack adds one cycle.
  - `stall_req` is high for every cycle except the ack cycle.
- `exc_misalign` and `bus_err` are high for exactly one cycle.
- `wb_wd` is 0 in every cycle that follows a stalled cycle (bubble).
- Back-to-back memory ops: the second enters IDLE on the ack edge. `d_req` therefore shows at least one low cycle between accesses.

## Test plan

- Reset, then an ALU op (op=0, data 0x1234_5678, addr 5, wd=1):
  - One cycle later, `wb_*` = 0x12345678/5/1; `stall_req` never 1.
- LB at addr 0x1003, ack on the 3rd BUSY cycle, `d_rdata`=0x80FF_0000:
  - `d_sel`=1000; `stall_req` high for 3 cycles.
  - `wb_w_reg_data`=0xFFFF_FF80.
  - LBU on the same stimulus gives 0x0000_0080.
- SH at 0x2002 with store data 0x0000_ABCD, immediate ack:
  - `d_we`=1, `d_sel`=1100, `d_wdata`=0xABCD_ABCD, `d_addr`=0x2000.
  - `wb_w_reg_data`=`men_w_reg_data`.
- LW at 0x3001:
  - `d_req` stays 0; `exc_misalign` pulses once.
  - `wb_wd`=0; `stall_req`=0.
- LW with no ack and `ACK_TIMEOUT`=4:
  - `bus_err` pulses after 4 BUSY cycles; `d_req` falls; state returns to IDLE.
  - A following ALU op proceeds normally.
- Assert `rst` asynchronously mid-BUSY:
  - `d_req`, `wb_wd` and `stall_req` go to 0 before the next edge.
  - An ack arriving after reset has no effect.

Source files
------------

// File: rtl/men_lsu.sv
// Memory-access stage: issues loads/stores on a req/ack bus, stalls upstream while
// an access is outstanding, and registers the write-back triple for MEM/WB.
module men_lsu #(
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] men_w_reg_data,
  input  logic [4:0]  men_w_reg_addr,
  input  logic        men_wd,
  input  logic [3:0]  men_mem_op,
  input  logic [31:0] men_mem_addr,
  input  logic [31:0] men_store_data,
  output logic        d_req,
  output logic        d_we,
  output logic [31:0] d_addr,
  output logic [3:0]  d_sel,
  output logic [31:0] d_wdata,
  input  logic [31:0] d_rdata,
  input  logic        d_ack,
  output logic        stall_req,
  output logic [31:0] wb_w_reg_data,
  output logic [4:0]  wb_w_reg_addr,
  output logic        wb_wd,
  output logic        exc_misalign,
  output logic        bus_err,
  output logic        dbg_state_o
);

  // Handshake: d_req rises on the edge leaving IDLE and stays high, with every d_*
  // field stable, until the edge that samples d_ack=1 or the watchdog abort.
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [TO_W:0] TO_LIM = (TO_W+1)'(ACK_TIMEOUT);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        d_req_q, d_req_d, d_we_q, d_we_d;
  logic [31:0] d_addr_q, d_addr_d, d_wdata_q, d_wdata_d;
  logic [3:0]  d_sel_q, d_sel_d, op_q, op_d;
  logic [1:0]  a_q, a_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic        wb_wd_q, wb_wd_d, exc_q, exc_d, err_q, err_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [TO_W:0]   cnt_inc;

  logic        is_load, is_store, sz_b, sz_h, sz_w, misalign, issue, abort, busy;
  logic [1:0]  a;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c, rshift, ld_data;
  logic [15:0] half_v;

  assign a        = men_mem_addr[1:0];
  assign is_load  = (men_mem_op >= OP_LB) && (men_mem_op <= OP_LW);
  assign is_store = (men_mem_op >= OP_SB) && (men_mem_op <= OP_SW);
  assign sz_b     = (men_mem_op == OP_LB) || (men_mem_op == OP_LBU) || (men_mem_op == OP_SB);
  assign sz_h     = (men_mem_op == OP_LH) || (men_mem_op == OP_LHU) || (men_mem_op == OP_SH);
  assign sz_w     = (men_mem_op == OP_LW) || (men_mem_op == OP_SW);
  assign misalign = (sz_h & a[0]) | (sz_w & (|a));
  assign busy     = (state_q == S_BUSY);
  assign issue    = (state_q == S_IDLE) & (is_load | is_store) & ~misalign;
  assign cnt_inc  = {1'b0, cnt_q} + (TO_W+1)'(1);
  assign abort    = busy & ~d_ack & (ACK_TIMEOUT != 0) & (cnt_inc == TO_LIM);

  // Held upstream stages must see stall drop as soon as reset is asserted.
  assign stall_req = ~rst & (issue | (busy & ~d_ack & ~abort));

  assign sel_c   = sz_w ? 4'b1111 : (sz_h ? (a[1] ? 4'b1100 : 4'b0011) : (4'b0001 << a));
  assign wdata_c = !is_store ? 32'd0 :
                   sz_b ? {4{men_store_data[7:0]}} :
                   sz_h ? {2{men_store_data[15:0]}} : men_store_data;

  assign rshift = d_rdata >> {a_q, 3'b000};
  assign half_v = a_q[1] ? d_rdata[31:16] : d_rdata[15:0];

  always_comb begin
    ld_data = 32'd0;
    case (op_q)
      OP_LB:   ld_data = {{24{rshift[7]}}, rshift[7:0]};
      OP_LBU:  ld_data = {24'd0, rshift[7:0]};
      OP_LH:   ld_data = {{16{half_v[15]}}, half_v};
      OP_LHU:  ld_data = {16'd0, half_v};
      OP_LW:   ld_data = d_rdata;
      default: ld_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      d_req_q   <= 1'b0;
      d_we_q    <= 1'b0;
      d_addr_q  <= 32'd0;
      d_sel_q   <= 4'd0;
      d_wdata_q <= 32'd0;
      op_q      <= 4'd0;
      a_q       <= 2'd0;
      wb_data_q <= 32'd0;
      wb_addr_q <= 5'd0;
      wb_wd_q   <= 1'b0;
      exc_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      d_req_q   <= d_req_d;
      d_we_q    <= d_we_d;
      d_addr_q  <= d_addr_d;
      d_sel_q   <= d_sel_d;
      d_wdata_q <= d_wdata_d;
      op_q      <= op_d;
      a_q       <= a_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
      wb_wd_q   <= wb_wd_d;
      exc_q     <= exc_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue) state_d = S_BUSY;
      S_BUSY:  if (d_ack || abort) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    d_req_d   = d_req_q;
    d_we_d    = d_we_q;
    d_addr_d  = d_addr_q;
    d_sel_d   = d_sel_q;
    d_wdata_d = d_wdata_q;
    op_d      = op_q;
    a_d       = a_q;
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    wb_wd_d   = wb_wd_q;
    exc_d     = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    if (state_q == S_IDLE) begin
      if (issue) begin
        d_req_d   = 1'b1;
        d_we_d    = is_store;
        d_addr_d  = {men_mem_addr[31:2], 2'b00};
        d_sel_d   = sel_c;
        d_wdata_d = wdata_c;
        op_d      = men_mem_op;
        a_d       = a;
        wb_wd_d   = 1'b0;
        cnt_d     = '0;
      end else if (is_load || is_store) begin
        wb_wd_d = 1'b0;
        exc_d   = 1'b1;
      end else begin
        wb_data_d = men_w_reg_data;
        wb_addr_d = men_w_reg_addr;
        wb_wd_d   = men_wd;
      end
    end else begin
      if (d_ack) begin
        d_req_d   = 1'b0;
        wb_addr_d = men_w_reg_addr;
        wb_wd_d   = men_wd;
        wb_data_d = d_we_q ? men_w_reg_data : ld_data;
      end else if (abort) begin
        d_req_d = 1'b0;
        err_d   = 1'b1;
        wb_wd_d = 1'b0;
      end else begin
        wb_wd_d = 1'b0;
        cnt_d   = cnt_inc[TO_W-1:0];
      end
    end
  end

  assign d_req         = d_req_q;
  assign d_we          = d_we_q;
  assign d_addr        = d_addr_q;
  assign d_sel         = d_sel_q;
  assign d_wdata       = d_wdata_q;
  assign wb_w_reg_data = wb_data_q;
  assign wb_w_reg_addr = wb_addr_q;
  assign wb_wd         = wb_wd_q;
  assign exc_misalign  = exc_q;
  assign bus_err       = err_q;
  assign dbg_state_o   = busy;

endmodule
